// File: rtl/decode_stage.sv
// MIPS ID stage: decode, 32x32 register file, operand forwarding, load-use detection, ID/EX register.
// Latency 1 cycle to ID/EX; stalls upstream (o_stall) for one cycle per load-use pair, no downstream backpressure.
module decode_stage #(
  parameter int NB_REG_ADDR = 5,
  parameter int NB_REG      = 32,
  parameter int NB_INSTR    = 32,
  parameter int NB_OPCODE   = 6,
  parameter int NB_PC       = 32
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_valid,
  input  logic [NB_INSTR-1:0]    i_instr,
  input  logic [NB_PC-1:0]       i_pc,
  input  logic                   i_flush,
  input  logic                   i_wb_we,
  input  logic [NB_REG_ADDR-1:0] i_wb_addr,
  input  logic [NB_REG-1:0]      i_wb_data,
  input  logic                   i_fwd_mux_a,
  input  logic                   i_fwd_mux_b,
  input  logic [NB_REG-1:0]      i_fwd_data_a,
  input  logic [NB_REG-1:0]      i_fwd_data_b,
  input  logic                   i_ex_mem_read,
  input  logic [NB_REG_ADDR-1:0] i_rd_ex,
  output logic [NB_REG_ADDR-1:0] o_rs,
  output logic [NB_REG_ADDR-1:0] o_rt,
  output logic                   o_stall,
  output logic                   o_valid,
  output logic [NB_REG-1:0]      o_data_a,
  output logic [NB_REG-1:0]      o_data_b,
  output logic [NB_REG-1:0]      o_imm,
  output logic [NB_REG_ADDR-1:0] o_rd,
  output logic [NB_OPCODE-1:0]   o_opcode,
  output logic [5:0]             o_funct,
  output logic                   o_we,
  output logic                   o_mem_read,
  output logic                   o_mem_write,
  output logic                   o_alu_src_imm,
  output logic [NB_PC-1:0]       o_pc
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  typedef struct packed {
    logic we;
    logic mem_read;
    logic mem_write;
    logic alu_src_imm;
  } ctrl_t;

  logic [NB_OPCODE-1:0]   opcode;
  logic [NB_REG_ADDR-1:0] rs, rt, rd_field, dest;
  logic [15:0]            imm16;
  logic [NB_REG-1:0]      regs [32];
  logic [NB_REG-1:0]      rf_a, rf_b, data_a, data_b, imm;
  ctrl_t                  ctrl;

  assign opcode   = i_instr[NB_INSTR-1 -: NB_OPCODE];
  assign rs       = i_instr[25:21];
  assign rt       = i_instr[20:16];
  assign rd_field = i_instr[15:11];
  assign imm16    = i_instr[15:0];
  assign o_rs     = rs;
  assign o_rt     = rt;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (i_wb_we && i_wb_addr != '0) begin
      regs[i_wb_addr] <= i_wb_data;
    end
  end

  // Write-through read; forwarding overrides both, and r0 overrides everything.
  always_comb begin
    rf_a = regs[rs];
    rf_b = regs[rt];
    if (i_wb_we && i_wb_addr == rs) rf_a = i_wb_data;
    if (i_wb_we && i_wb_addr == rt) rf_b = i_wb_data;
    data_a = '0;
    data_b = '0;
    if (rs != '0) data_a = i_fwd_mux_a ? i_fwd_data_a : rf_a;
    if (rt != '0) data_b = i_fwd_mux_b ? i_fwd_data_b : rf_b;
  end

  always_comb begin
    ctrl = '0;
    dest = '0;
    imm  = {{(NB_REG-16){imm16[15]}}, imm16};
    case (opcode)
      OP_RTYPE: begin
        dest    = rd_field;
        ctrl.we = 1'b1;
      end
      OP_LW: begin
        dest = rt;
        ctrl = '{we: 1'b1, mem_read: 1'b1, mem_write: 1'b0, alu_src_imm: 1'b1};
      end
      OP_SW: begin
        ctrl = '{we: 1'b0, mem_read: 1'b0, mem_write: 1'b1, alu_src_imm: 1'b1};
      end
      OP_ADDI, OP_ADDIU, OP_SLTI: begin
        dest = rt;
        ctrl = '{we: 1'b1, mem_read: 1'b0, mem_write: 1'b0, alu_src_imm: 1'b1};
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        dest = rt;
        ctrl = '{we: 1'b1, mem_read: 1'b0, mem_write: 1'b0, alu_src_imm: 1'b1};
        imm  = {{(NB_REG-16){1'b0}}, imm16};
      end
      OP_LUI: begin
        dest = rt;
        ctrl = '{we: 1'b1, mem_read: 1'b0, mem_write: 1'b0, alu_src_imm: 1'b1};
        imm  = {imm16, {(NB_REG-16){1'b0}}};
      end
      OP_BEQ, OP_BNE: begin
        ctrl = '0;
      end
      default: begin
        ctrl = '0;
      end
    endcase
    if (dest == '0) ctrl.we = 1'b0;
    if (!i_valid) ctrl = '0;
  end

  assign o_stall = i_valid & ~i_flush & i_ex_mem_read & (i_rd_ex != '0) &
                   ((rs == i_rd_ex) | (rt == i_rd_ex));

  // Flush and stall both insert a fully zeroed bubble.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      o_valid       <= 1'b0;
      o_data_a      <= '0;
      o_data_b      <= '0;
      o_imm         <= '0;
      o_rd          <= '0;
      o_opcode      <= '0;
      o_funct       <= '0;
      o_we          <= 1'b0;
      o_mem_read    <= 1'b0;
      o_mem_write   <= 1'b0;
      o_alu_src_imm <= 1'b0;
      o_pc          <= '0;
    end else if (i_flush || o_stall) begin
      o_valid       <= 1'b0;
      o_data_a      <= '0;
      o_data_b      <= '0;
      o_imm         <= '0;
      o_rd          <= '0;
      o_opcode      <= '0;
      o_funct       <= '0;
      o_we          <= 1'b0;
      o_mem_read    <= 1'b0;
      o_mem_write   <= 1'b0;
      o_alu_src_imm <= 1'b0;
      o_pc          <= '0;
    end else begin
      o_valid       <= i_valid;
      o_data_a      <= data_a;
      o_data_b      <= data_b;
      o_imm         <= imm;
      o_rd          <= dest;
      o_opcode      <= opcode;
      o_funct       <= i_instr[5:0];
      o_we          <= ctrl.we;
      o_mem_read    <= ctrl.mem_read;
      o_mem_write   <= ctrl.mem_write;
      o_alu_src_imm <= ctrl.alu_src_imm;
      o_pc          <= i_pc;
    end
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
MIPS ID stage: decodes the instruction, reads a 32x32 register file, applies the forwarded operands from the shortcircuit unit, detects load-use hazards, and registers everything into the ID/EX pipeline register. It sits upstream of EX. It exports rs/rt to the shortcircuit unit and consumes that unit's o_mux_a/o_mux_b/o_data_a/o_data_b.

Parameters:
NB_REG_ADDR, 5, register address width
NB_REG, 32, register/data width
NB_INSTR, 32, instruction width
NB_OPCODE, 6, opcode field width
NB_PC, 32, program counter width

Ports:
i_clock  in  1  clock, all state on rising edge
i_reset  in  1  asynchronous, active-high reset
i_valid  in  1  i_instr/i_pc hold a real instruction
i_instr  in  NB_INSTR  instruction from IF/ID
i_pc  in  NB_PC  PC+4 of i_instr
i_flush  in  1  branch/jump taken: discard the decoding instruction
i_wb_we  in  1  write-back enable
i_wb_addr  in  NB_REG_ADDR  write-back register
i_wb_data  in  NB_REG  write-back data
i_fwd_mux_a / i_fwd_mux_b  in  1  use forwarded operand A/B
i_fwd_data_a / i_fwd_data_b  in  NB_REG  forwarded operand A/B
i_ex_mem_read  in  1  instruction in EX is a load
i_rd_ex  in  NB_REG_ADDR  destination of instruction in EX
o_rs / o_rt  out  NB_REG_ADDR  combinational instr[25:21]/[20:16], to shortcircuit unit
o_stall  out  1  combinational load-use stall to PC and IF/ID
o_valid  out  1  ID/EX holds a real instruction
o_data_a / o_data_b  out  NB_REG  registered operands
o_imm  out  NB_REG  registered extended immediate
o_rd  out  NB_REG_ADDR  registered destination register
o_opcode  out  NB_OPCODE  registered opcode
o_funct  out  6  registered funct field
o_we / o_mem_read / o_mem_write / o_alu_src_imm  out  1  registered controls
o_pc  out  NB_PC  registered PC+4

Behaviour:
- Reset (asynchronous, i_reset=1): all 32 registers = 0; all ID/EX outputs = 0 (o_valid=0 is a bubble). Reset mid-stall drops the bubble/stall state; no state beyond the register file and ID/EX.
- Register file: write at rising edge when i_wb_we & i_wb_addr!=0. Register 0 reads 0 and is never written. Read is write-through: a same-cycle write to the read address returns i_wb_data.
- Operand select, per A (rs) and B (rt): address 0 -> 0 (forwarding ignored); else fwd_mux ? fwd_data : regfile read.
- Decode, by opcode:
  - 000000 R-type: rd=instr[15:11], we=1.
  - 100011 LW: rd=rt, we=1, mem_read=1, alu_src_imm=1.
  - 101011 SW: we=0, mem_write=1, alu_src_imm=1.
  - 001000/001001/001010 ADDI/ADDIU/SLTI: rd=rt, we=1, alu_src_imm=1, imm sign-extended.
  - 001100/001101/001110 ANDI/ORI/XORI: as above, imm zero-extended.
  - 001111 LUI: imm = {instr[15:0],16'b0}, rd=rt, we=1, alu_src_imm=1.
  - 000100/000101 BEQ/BNE: we=0, imm sign-extended.
  - Any other opcode: all controls 0, o_valid still follows i_valid.
  - o_we forced 0 when the destination is 0.
- Hazard: o_stall = i_valid & ~i_flush & i_ex_mem_read & i_rd_ex!=0 & (rs==i_rd_ex | rt==i_rd_ex).
- ID/EX update, each rising edge, priority order:
  1. i_flush: bubble, so o_valid, o_we, o_mem_read, o_mem_write = 0; data fields don't-care, drive 0.
  2. o_stall: bubble, same as flush. Upstream holds i_instr, so the next cycle re-decodes with forwarding now from MEM.
  3. Otherwise: capture decoded fields; o_valid = i_valid; controls gated by i_valid.
- Latency: 1 cycle from i_instr to ID/EX outputs. A stall costs exactly 1 bubble per load-use pair.
- Simultaneous flush and stall: flush wins and o_stall=0.
- Simultaneous WB write and forward: the forward wins.

Test Plan:
- Reset: assert i_reset asynchronously mid-cycle -> every output 0 immediately; reading r5 returns 0.
- Write-through: i_wb_we=1, addr=5, data=0xDEADBEEF with ADD $3,$5,$0 decoding -> next edge o_data_a=0xDEADBEEF, o_data_b=0, o_rd=3, o_we=1.
- Forwarding and zero: i_fwd_mux_a=1, data=0x11 with rs=7 -> o_data_a=0x11. Same with rs=0 -> o_data_a=0.
- Load-use: i_ex_mem_read=1, i_rd_ex=4, instr ADD $2,$4,$1 -> o_stall=1, next o_valid=0. Then i_ex_mem_read=0 -> o_stall=0, instruction issues with o_rd=2.
- Flush priority: i_flush=1 together with the load-use condition above -> o_stall=0, next o_valid=0, o_we=0.
- Immediates: ADDI imm 0xFFFF -> o_imm=0xFFFFFFFF. ORI 0xFFFF -> 0x0000FFFF. LUI 0x1234 -> 0x12340000. SW -> o_we=0, o_mem_write=1.
